pulse_gen_multi: RTL and testbench
==================================

PULSE_GEN_MULTI -- requirements
Module: pulse_gen_multi

Interface
REQ-001 SHALL have parameter CLKS_PER_1_US, default 10, i_clk cycles per microsecond (>=2).
REQ-002 SHALL have parameter N_CH, default 4, number of independent pulse channels (1-8).
REQ-003 SHALL have ports: i_clk in 1 system clock; i_rst_n in 1 reset, asynchronous, active-low.
REQ-004 SHALL have ports: i_pps_raw in 1 asynchronous PPS; i_thunder_packet_dv in 1 time-of-day valid strobe.
REQ-005 SHALL have ports: i_thunder_time in 56 {year[15:0],month,day,hour,minutes,seconds}; i_usr_time in N_CH*56 per-channel start time, same packing.
REQ-006 SHALL have ports: i_enable in N_CH channel enable; i_arm in N_CH one-cycle arm strobe.
REQ-007 SHALL have ports: i_width_high, i_width_period, i_pulse_count, i_phase_us, each in N_CH*32, microseconds or pulses, channel ch at bits [32*ch+31:32*ch].
REQ-008 SHALL have ports: o_pulse_out out N_CH registered pulses; o_busy out N_CH channel not IDLE; o_done out N_CH one-cycle completion strobe.

Function
REQ-009 SHALL pass i_pps_raw through a 3-flop synchroniser; pps_edge = stage1 & ~stage2, one cycle per rising edge.
REQ-010 SHALL keep a shared tick counter 0..CLKS_PER_1_US-1, forced to 0 on pps_edge; us_tick asserts when it equals CLKS_PER_1_US-1.
REQ-011 Each channel SHALL run an FSM: IDLE, ARMED, WAIT_PPS, PHASE, RUN.
REQ-012 IDLE->ARMED when i_arm[ch] & i_enable[ch]; i_arm ignored in any other state.
REQ-013 ARMED->WAIT_PPS in the cycle i_thunder_packet_dv is high and i_thunder_time equals i_usr_time[ch] on all 56 bits.
REQ-014 WAIT_PPS->PHASE on pps_edge; PHASE->RUN when phase counter reaches i_phase_us[ch] (immediately if 0, same pps_edge cycle going straight to RUN).
REQ-015 In RUN, micro counter SHALL increment on us_tick, wrap to 0 at max(i_width_period,1)-1; period counter increments at each wrap.
REQ-016 o_pulse_out[ch] SHALL register (RUN & micro < i_width_high[ch]); width_high >= period gives constant high; width_high 0 gives constant low.
REQ-017 o_pulse_out[ch] SHALL first assert on the 4th rising i_clk after i_pps_raw is first sampled high (phase 0).
REQ-018 i_pulse_count[ch]=0 SHALL mean continuous; otherwise after i_pulse_count periods complete, RUN->IDLE and o_done[ch] pulses one cycle.
REQ-019 Deassertion of i_enable[ch] in any state SHALL force IDLE next cycle, clear counters, no o_done; o_pulse_out[ch] low one cycle later.
REQ-020 Config inputs SHALL be sampled live; changing i_width_period below current micro count SHALL wrap micro to 0 on next us_tick.
REQ-021 Channels SHALL be fully independent except shared synchroniser and tick counter; arm and pps_edge in same cycle for one channel only advances one state.
REQ-022 All counters SHALL be 32-bit, saturating never required; phase and micro counters count us_tick only.

Reset
REQ-023 i_rst_n low SHALL asynchronously clear synchroniser, tick counter, all FSMs to IDLE, all counters to 0.
REQ-024 Reset values: o_pulse_out=0, o_busy=0, o_done=0; release mid-pulse restarts from IDLE requiring new i_arm.

Configuration
REQ-025 Macro PULSE_GEN_PHASE_EN defined: PHASE state and i_phase_us honoured per REQ-014.
REQ-026 Macro PULSE_GEN_PHASE_EN undefined: i_phase_us port kept but ignored, PHASE state absent, WAIT_PPS->RUN directly on pps_edge.

Verification
REQ-027 N_CH=4, CLKS_PER_1_US=10, ch0 width 3/period 10, count 0, armed, time match, PPS -> ch0 high 30 clk, low 70 clk, repeating, first rise 4 clk after PPS.
REQ-028 ch1 count 2, width 5/period 8 -> exactly two 50-clk pulses, o_done[1] one cycle after second period, o_busy[1] falls.
REQ-029 ch2 i_usr_time mismatch by 1 second -> stays ARMED, o_pulse_out[2]=0 across 3 PPS; matching packet next -> runs after following PPS.
REQ-030 PULSE_GEN_PHASE_EN, ch3 phase 5 -> first rise 50 clk later than ch0 started on same PPS; undefined -> same cycle as ch0.
REQ-031 i_rst_n low mid-pulse -> o_pulse_out=0 immediately; i_enable[0] low mid-pulse -> ch0 IDLE, low within 2 clk, other channels unaffected.

Source files
------------

// File: rtl/pulse_gen_multi_if.sv
// Signal bundle for pulse_gen_multi: PPS and time-of-day inputs, per-channel
// configuration, and per-channel pulse/busy/done outputs.
interface pulse_gen_multi_if #(
    parameter int N_CH = 4
);
    logic                 i_pps_raw;
    logic                 i_thunder_packet_dv;
    logic [55:0]          i_thunder_time;
    logic [N_CH*56-1:0]   i_usr_time;
    logic [N_CH-1:0]      i_enable;
    logic [N_CH-1:0]      i_arm;
    logic [N_CH*32-1:0]   i_width_high;
    logic [N_CH*32-1:0]   i_width_period;
    logic [N_CH*32-1:0]   i_pulse_count;
    logic [N_CH*32-1:0]   i_phase_us;
    logic [N_CH-1:0]      o_pulse_out;
    logic [N_CH-1:0]      o_busy;
    logic [N_CH-1:0]      o_done;

    modport master (
        output i_pps_raw, i_thunder_packet_dv, i_thunder_time, i_usr_time,
        output i_enable, i_arm, i_width_high, i_width_period, i_pulse_count, i_phase_us,
        input  o_pulse_out, o_busy, o_done
    );

    modport slave (
        input  i_pps_raw, i_thunder_packet_dv, i_thunder_time, i_usr_time,
        input  i_enable, i_arm, i_width_high, i_width_period, i_pulse_count, i_phase_us,
        output o_pulse_out, o_busy, o_done
    );
endinterface

// File: rtl/pulse_gen_multi.sv
// PPS-aligned multi-channel microsecond pulse generator.
// Define PULSE_GEN_PHASE_EN to honour i_phase_us (PHASE delay after PPS).
module pulse_gen_multi #(
    parameter int CLKS_PER_1_US = 10,
    parameter int N_CH          = 4
) (
    input logic              i_clk,
    input logic              i_rst_n,
    pulse_gen_multi_if.slave bus
);

`ifdef PULSE_GEN_PHASE_EN
    typedef enum logic [2:0] {IDLE, ARMED, WAIT_PPS, PHASE, RUN} state_t;
`else
    typedef enum logic [2:0] {IDLE, ARMED, WAIT_PPS, RUN} state_t;
`endif

    localparam logic [31:0] TICK_MAX = 32'(CLKS_PER_1_US - 1);

    logic [2:0]      pps_sync;
    logic            pps_edge;
    logic [31:0]     tick_cnt;
    logic            us_tick;

    state_t          state_q     [N_CH];
    state_t          state_d     [N_CH];
    logic [31:0]     micro_q     [N_CH];
    logic [31:0]     micro_d     [N_CH];
    logic [31:0]     period_q    [N_CH];
    logic [31:0]     period_d    [N_CH];
    logic [31:0]     width_high  [N_CH];
    logic [31:0]     wrap_at     [N_CH];
    logic [31:0]     pulse_count [N_CH];
    logic [N_CH-1:0] time_hit;
    logic [N_CH-1:0] done_d;
    logic [N_CH-1:0] done_q;
    logic [N_CH-1:0] pulse_q;
    logic [N_CH-1:0] busy;

`ifdef PULSE_GEN_PHASE_EN
    logic [31:0]     phase_us    [N_CH];
    logic [31:0]     phase_q     [N_CH];
    logic [31:0]     phase_d     [N_CH];
`else
    logic            unused_phase;
    assign unused_phase = ^bus.i_phase_us;
`endif

    // Edge is taken between the 2nd and 3rd flop so the first pulse lands
    // on the 4th clock after PPS is first sampled.
    assign pps_edge = pps_sync[1] & ~pps_sync[2];
    assign us_tick  = (tick_cnt == TICK_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pps_sync <= '0;
            tick_cnt <= '0;
        end else begin
            pps_sync <= {pps_sync[1:0], bus.i_pps_raw};
            if (pps_edge || us_tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        time_hit = '0;
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            width_high[ch]  = bus.i_width_high[32*ch +: 32];
            pulse_count[ch] = bus.i_pulse_count[32*ch +: 32];
            // period 0 behaves as period 1: micro never leaves 0
            wrap_at[ch]     = (bus.i_width_period[32*ch +: 32] == '0) ? '0
                            : bus.i_width_period[32*ch +: 32] - 32'd1;
            time_hit[ch]    = bus.i_thunder_packet_dv &&
                              (bus.i_thunder_time == bus.i_usr_time[56*ch +: 56]);
`ifdef PULSE_GEN_PHASE_EN
            phase_us[ch]    = bus.i_phase_us[32*ch +: 32];
`endif
        end
    end

    always_comb begin
        done_d = '0;
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            state_d[ch]  = state_q[ch];
            micro_d[ch]  = micro_q[ch];
            period_d[ch] = period_q[ch];
`ifdef PULSE_GEN_PHASE_EN
            phase_d[ch]  = phase_q[ch];
`endif
            if (!bus.i_enable[ch]) begin
                state_d[ch]  = IDLE;
                micro_d[ch]  = '0;
                period_d[ch] = '0;
`ifdef PULSE_GEN_PHASE_EN
                phase_d[ch]  = '0;
`endif
            end else begin
                case (state_q[ch])
                    IDLE: begin
                        if (bus.i_arm[ch]) state_d[ch] = ARMED;
                    end
                    ARMED: begin
                        if (time_hit[ch]) state_d[ch] = WAIT_PPS;
                    end
                    WAIT_PPS: begin
                        if (pps_edge) begin
                            micro_d[ch]  = '0;
                            period_d[ch] = '0;
`ifdef PULSE_GEN_PHASE_EN
                            phase_d[ch]  = '0;
                            state_d[ch]  = (phase_us[ch] == '0) ? RUN : PHASE;
`else
                            state_d[ch]  = RUN;
`endif
                        end
                    end
`ifdef PULSE_GEN_PHASE_EN
                    PHASE: begin
                        if (phase_q[ch] >= phase_us[ch]) begin
                            state_d[ch] = RUN;
                        end else if (us_tick) begin
                            phase_d[ch] = phase_q[ch] + 32'd1;
                            if (phase_q[ch] + 32'd1 >= phase_us[ch]) state_d[ch] = RUN;
                        end
                    end
`endif
                    RUN: begin
                        if (us_tick) begin
                            // >= so a live period reduction wraps on the next tick
                            if (micro_q[ch] >= wrap_at[ch]) begin
                                micro_d[ch]  = '0;
                                period_d[ch] = period_q[ch] + 32'd1;
                                if ((pulse_count[ch] != '0) &&
                                    (period_q[ch] + 32'd1 >= pulse_count[ch])) begin
                                    state_d[ch]  = IDLE;
                                    period_d[ch] = '0;
                                    done_d[ch]   = 1'b1;
                                end
                            end else begin
                                micro_d[ch] = micro_q[ch] + 32'd1;
                            end
                        end
                    end
                    default: state_d[ch] = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                state_q[ch]  <= IDLE;
                micro_q[ch]  <= '0;
                period_q[ch] <= '0;
`ifdef PULSE_GEN_PHASE_EN
                phase_q[ch]  <= '0;
`endif
            end
            pulse_q <= '0;
            done_q  <= '0;
        end else begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                state_q[ch]  <= state_d[ch];
                micro_q[ch]  <= micro_d[ch];
                period_q[ch] <= period_d[ch];
`ifdef PULSE_GEN_PHASE_EN
                phase_q[ch]  <= phase_d[ch];
`endif
                pulse_q[ch]  <= (state_q[ch] == RUN) && (micro_q[ch] < width_high[ch]);
            end
            done_q <= done_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            busy[ch] = (state_q[ch] != IDLE);
        end
    end

    assign bus.o_pulse_out = pulse_q;
    assign bus.o_busy      = busy;
    assign bus.o_done      = done_q;

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Self-checking bench for pulse_gen_multi: elapsed-microsecond reference model
// checked every cycle, plus hand-computed timing expectations.
module tb_pulse_gen_multi;
    localparam int CLKS = 10;
    localparam int NCH  = 4;
    localparam logic [55:0] T0 = {16'd2024, 8'd6, 8'd15, 8'd12, 8'd30, 8'd45};
    localparam logic [55:0] T1 = {16'd2024, 8'd6, 8'd15, 8'd12, 8'd30, 8'd46};
`ifdef PULSE_GEN_PHASE_EN
    localparam int PHASE_ON = 1;
`else
    localparam int PHASE_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    pulse_gen_multi_if #(.N_CH(NCH)) bus ();

    pulse_gen_multi #(.CLKS_PER_1_US(CLKS), .N_CH(NCH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: channel state plus microseconds elapsed since RUN began.
    int              n_edge;
    int              tick_ref;
    bit              r1, r2, r3;
    bit              pps_ev, us_ev;
    int              m_st [NCH];
    longint          m_us [NCH];
    longint          m_ph [NCH];
    longint          wh, per, cnt, ph;
    logic [NCH-1:0]  exp_pulse = '0;
    logic [NCH-1:0]  exp_busy  = '0;
    logic [NCH-1:0]  exp_done  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_edge = 0; tick_ref = 0; r1 = 0; r2 = 0; r3 = 0;
            for (int c = 0; c < NCH; c++) begin
                m_st[c] = 0; m_us[c] = 0; m_ph[c] = 0;
            end
            exp_pulse = '0; exp_busy = '0; exp_done = '0;
        end else begin
            n_edge++;
            us_ev  = ((n_edge - 1 - tick_ref) % CLKS) == CLKS - 1;
            // PPS rise sampled two edges ago is acted on now
            pps_ev = r2 && !r3;
            r3 = r2; r2 = r1; r1 = bus.i_pps_raw;
            if (pps_ev) tick_ref = n_edge;
            for (int c = 0; c < NCH; c++) begin
                wh  = bus.i_width_high[32*c +: 32];
                per = bus.i_width_period[32*c +: 32];
                if (per == 0) per = 1;
                cnt = bus.i_pulse_count[32*c +: 32];
                ph  = PHASE_ON ? longint'(bus.i_phase_us[32*c +: 32]) : 0;
                exp_pulse[c] = (m_st[c] == 4) && ((m_us[c] % per) < wh);
                exp_done[c]  = 1'b0;
                if (!bus.i_enable[c]) begin
                    m_st[c] = 0;
                end else begin
                    case (m_st[c])
                        0: if (bus.i_arm[c]) m_st[c] = 1;
                        1: if (bus.i_thunder_packet_dv &&
                               bus.i_thunder_time == bus.i_usr_time[56*c +: 56]) m_st[c] = 2;
                        2: if (pps_ev) begin
                               m_us[c] = 0; m_ph[c] = 0;
                               m_st[c] = (ph == 0) ? 4 : 3;
                           end
                        3: if (us_ev) begin
                               m_ph[c]++;
                               if (m_ph[c] >= ph) m_st[c] = 4;
                           end
                        4: if (us_ev) begin
                               m_us[c]++;
                               if (cnt != 0 && m_us[c] == per * cnt) begin
                                   m_st[c] = 0;
                                   exp_done[c] = 1'b1;
                               end
                           end
                        default: m_st[c] = 0;
                    endcase
                end
                exp_busy[c] = (m_st[c] != 0);
            end
        end
    end

    always @(negedge clk) begin
        check("pulse_out vs model", bus.o_pulse_out, exp_pulse);
        check("busy vs model", bus.o_busy, exp_busy);
        check("done vs model", bus.o_done, exp_done);
    end

    // Edge recorder used by the hand-computed timing checks.
    int             rise_q [NCH][$];
    int             fall_q [NCH][$];
    int             done_q [NCH][$];
    logic [NCH-1:0] prev_pulse = '0;

    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (bus.o_pulse_out[c] && !prev_pulse[c]) rise_q[c].push_back(cyc);
            if (!bus.o_pulse_out[c] && prev_pulse[c]) fall_q[c].push_back(cyc);
            if (bus.o_done[c]) done_q[c].push_back(cyc);
        end
        prev_pulse = bus.o_pulse_out;
    end

    function automatic int rget(input int c, input int i);
        if (i < rise_q[c].size()) return rise_q[c][i];
        return -1;
    endfunction
    function automatic int fget(input int c, input int i);
        if (i < fall_q[c].size()) return fall_q[c][i];
        return -1;
    endfunction
    function automatic int dget(input int c, input int i);
        if (i < done_q[c].size()) return done_q[c][i];
        return -1;
    endfunction

    task automatic clear_mon();
        for (int c = 0; c < NCH; c++) begin
            rise_q[c].delete(); fall_q[c].delete(); done_q[c].delete();
        end
    endtask

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic cfg(input int c, input logic [31:0] w, input logic [31:0] p,
                       input logic [31:0] n, input logic [31:0] phs, input logic [55:0] ut);
        bus.i_width_high[32*c +: 32]   = w;
        bus.i_width_period[32*c +: 32] = p;
        bus.i_pulse_count[32*c +: 32]  = n;
        bus.i_phase_us[32*c +: 32]     = phs;
        bus.i_usr_time[56*c +: 56]     = ut;
    endtask

    task automatic arm(input logic [NCH-1:0] m);
        step(); bus.i_arm = m;
        step(); bus.i_arm = '0;
    endtask

    task automatic packet(input logic [55:0] t);
        step(); bus.i_thunder_time = t; bus.i_thunder_packet_dv = 1'b1;
        step(); bus.i_thunder_packet_dv = 1'b0;
    endtask

    // s = cycle number of the edge that first samples PPS high
    task automatic pps(output int s);
        step(); bus.i_pps_raw = 1'b1; s = cyc + 1;
        repeat (20) step();
        bus.i_pps_raw = 1'b0;
    endtask

    task automatic wait_out(input int c, input int budget);
        int i = 0;
        while (!bus.o_pulse_out[c] && i < budget) begin
            @(negedge clk); i++;
        end
        check($sformatf("ch%0d pulse seen within budget", c), bus.o_pulse_out[c], 1);
    endtask

    initial begin
        int s1, s2, s3, s4, s5, s6;
        rst_n = 1'b0;
        bus.i_pps_raw = 1'b0; bus.i_thunder_packet_dv = 1'b0; bus.i_thunder_time = '0;
        bus.i_usr_time = '0; bus.i_enable = '0; bus.i_arm = '0;
        bus.i_width_high = '0; bus.i_width_period = '0; bus.i_pulse_count = '0; bus.i_phase_us = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset pulse_out", bus.o_pulse_out, 0);
        check("reset busy", bus.o_busy, 0);
        check("reset done", bus.o_done, 0);
        step(); rst_n = 1'b1;

        // Main run: continuous, counted, mismatched time, phase-shifted
        cfg(0, 3, 10, 0, 0, T0);
        cfg(1, 5, 8, 2, 0, T0);
        cfg(2, 2, 4, 0, 0, T1);
        cfg(3, 4, 10, 0, 5, T0);
        bus.i_enable = '1;
        arm('1);
        packet(T0);
        repeat (5) step();
        clear_mon();
        pps(s1);
        wait_until(s1 + 380);
        check("ch0 first rise", rget(0, 0), s1 + 3);
        check("ch0 high width", fget(0, 0) - rget(0, 0), 30);
        check("ch0 low width", rget(0, 1) - fget(0, 0), 70);
        check("ch1 pulse count", rise_q[1].size(), 2);
        check("ch1 width 0", fget(1, 0) - rget(1, 0), 50);
        check("ch1 width 1", fget(1, 1) - rget(1, 1), 50);
        check("ch1 second rise", rget(1, 1), s1 + 83);
        check("ch1 done strobes", done_q[1].size(), 1);
        check("ch1 done time", dget(1, 0), s1 + 162);
        check("ch1 busy after done", bus.o_busy[1], 0);
        check("ch3 rise offset", rget(3, 0) - rget(0, 0), PHASE_ON ? 50 : 0);

        // ch2 time mismatch keeps it armed across PPS
        pps(s2); wait_until(s2 + 300);
        pps(s3); wait_until(s3 + 300);
        check("ch2 no pulse while armed", rise_q[2].size(), 0);
        check("ch2 still armed", bus.o_busy[2], 1);
        packet(T1);
        repeat (5) step();
        pps(s4);
        wait_until(s4 + 60);
        check("ch2 first rise", rget(2, 0), s4 + 3);
        check("ch2 high width", fget(2, 0) - rget(2, 0), 20);

        // Disable ch0 mid-pulse
        wait_out(0, 200);
        step(); bus.i_enable[0] = 1'b0;
        step(); step();
        check("ch0 low after disable", bus.o_pulse_out[0], 0);
        check("ch0 idle after disable", bus.o_busy[0], 0);
        check("ch2 unaffected", bus.o_busy[2], 1);
        check("ch3 unaffected", bus.o_busy[3], 1);

        // Asynchronous reset mid-pulse, then no re-arm
        wait_out(2, 100);
        step(); #1 rst_n = 1'b0;
        #1;
        check("async reset pulse_out", bus.o_pulse_out, 0);
        check("async reset busy", bus.o_busy, 0);
        repeat (3) step();
        rst_n = 1'b1;
        bus.i_enable = '1;
        packet(T0);
        packet(T1);
        pps(s5);
        wait_until(s5 + 30);
        check("no run without arm busy", bus.o_busy, 0);
        check("no run without arm pulse", bus.o_pulse_out, 0);

        // Boundary widths/periods and single-shot count
        cfg(0, 0, 10, 0, 0, T0);
        cfg(1, 12, 8, 0, 0, T0);
        cfg(2, 3, 4, 1, 0, T0);
        cfg(3, 1, 0, 0, 0, T0);
        arm('1);
        packet(T0);
        repeat (5) step();
        clear_mon();
        pps(s6);
        wait_until(s6 + 200);
        check("width 0 never high", rise_q[0].size(), 0);
        check("width>=period rises once", rise_q[1].size(), 1);
        check("width>=period rise time", rget(1, 0), s6 + 3);
        check("width>=period still high", bus.o_pulse_out[1], 1);
        check("single shot width", fget(2, 0) - rget(2, 0), 30);
        check("single shot done time", dget(2, 0), s6 + 42);
        check("single shot idle", bus.o_busy[2], 0);
        check("period 0 still high", bus.o_pulse_out[3], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
